// File: rtl/regfile_wr_arb_pkg.sv
// Shared register-file geometry and the write-arbiter state encoding.
// Imported by the arbiter interface, the grant search and the top level.
package regfile_pkg;

  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 32;

  typedef logic [0:0] state_t;
  localparam state_t ARB   = 1'b0;
  localparam state_t CLEAR = 1'b1;

  // Successor of requester g in an n-entry ring.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Bundle of requester handshakes, clear control and the register-file write port.
// master = requesters/controller side, slave = the arbiter.
interface regfile_wr_arb_if
  import regfile_pkg::*;
#(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clr_start;
  logic               clr_busy;
  logic               clr_done;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               wena;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, clr_busy, clr_done, waddr, wdata, wena
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, clr_busy, clr_done, waddr, wdata, wena
  );

endinterface

// File: rtl/regfile_wr_arb_rr_arbiter.sv
// Single-winner grant search over req_i, starting at ptr_i (or at 0 when
// fixed_pri_sel_i is set) and wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            fixed_pri_sel_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o
);

  always_comb begin : search
    int   start;
    int   idx;
    logic found;
    // NOTE: combinational blocks use blocking '=' so later lines see the
    // updated value within the same evaluation; flops use '<=' instead.
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    start       = fixed_pri_sel_i ? 0 : int'(ptr_i);
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Shares the register-file write port among NREQ requesters and runs a clear sweep.
// Define REGFILE_ARB_FIXED_PRI_EN for lowest-index-wins priority instead of round-robin.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic             clk,
  input  logic             rst,
  regfile_wr_arb_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          wena_q, wena_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;

  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   arb_ptr;
  logic            fixed_pri_sel;
  logic            xfer;

  // A pending clear or a running sweep owns the port, so nobody is offered ready.
  assign arb_req = (state_q == ARB && !bus.clr_start) ? bus.req_valid : '0;
  assign xfer    = |grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req_i           (arb_req),
    .ptr_i           (arb_ptr),
    .fixed_pri_sel_i (fixed_pri_sel),
    .grant_o         (grant),
    .grant_idx_o     (grant_idx)
  );

`ifdef REGFILE_ARB_FIXED_PRI_EN
  assign fixed_pri_sel = 1'b1;
  assign arb_ptr       = '0;
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  assign fixed_pri_sel = 1'b0;
  assign arb_ptr       = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = IW'(rr_next(int'(grant_idx), NREQ));
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wena_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.clr_start) begin
          // Address 0 is written on this edge; the counter then points at 1.
          state_d    = CLEAR;
          wena_d     = 1'b1;
          waddr_d    = '0;
          wdata_d    = '0;
          clr_cnt_d  = AW'(1);
          clr_busy_d = 1'b1;
        end else if (xfer) begin
          wena_d  = 1'b1;
          waddr_d = bus.req_addr[int'(grant_idx)*AW +: AW];
          wdata_d = bus.req_data[int'(grant_idx)*DW +: DW];
        end
      end
      CLEAR: begin
        wena_d     = 1'b1;
        waddr_d    = clr_cnt_q;
        wdata_d    = '0;
        clr_busy_d = 1'b1;
        clr_cnt_d  = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          clr_done_d = 1'b1;
          state_d    = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking '<=' so all registers update together
    // from the values present before the edge.
    if (rst) begin
      state_q    <= ARB;
      clr_cnt_q  <= '0;
      wena_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wena_q     <= wena_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.wena      = wena_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.clr_done  = clr_done_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: expected writes are queued when stimulus
// is driven and popped by a write-port monitor on the falling edge.
module tb_regfile_wr_arb;
  import regfile_pkg::*;

  localparam int NREQ = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_arb_if #(.NREQ(NREQ)) bus ();

  regfile_wr_arb #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t sb_q[$];
  wr_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;
  bit  mon_en      = 1'b0;

`ifdef REGFILE_ARB_FIXED_PRI_EN
  int exp_order[6] = '{0, 0, 0, 0, 0, 0};
`else
  int exp_order[6] = '{0, 1, 2, 0, 1, 2};
`endif

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.done = done;
    sb_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int k = 0; k < DEPTH; k++) push(AW'(k), '0, k == DEPTH - 1);
  endtask

  // Write-port monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wena === 1'b1) begin
        check("write_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("wr_addr", 64'(bus.waddr), 64'(mon_e.addr));
          check("wr_data", bus.wdata, mon_e.data);
          check("wr_done", 64'(bus.clr_done), 64'(mon_e.done));
        end
      end else begin
        check("idle_done", 64'(bus.clr_done), 64'd0);
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.clr_start = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    check("rst_wena", 64'(bus.wena), 64'd0);
    check("rst_waddr", 64'(bus.waddr), 64'd0);
    check("rst_wdata", bus.wdata, 64'd0);
    check("rst_busy", 64'(bus.clr_busy), 64'd0);
    check("rst_done", 64'(bus.clr_done), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    repeat (5) begin
      tick();
      check("idle_wena", 64'(bus.wena), 64'd0);
      check("idle_waddr", 64'(bus.waddr), 64'd0);
      check("idle_wdata", bus.wdata, 64'd0);
      check("idle_ready", 64'(bus.req_ready), 64'd0);
      check("idle_busy", 64'(bus.clr_busy), 64'd0);
    end

    // Single write from requester 1, one-cycle latency, then hold
    set_req(1, 5'd7, 64'hDEAD_BEEF);
    bus.req_valid = 3'b010;
    #1;
    check("single_ready", 64'(bus.req_ready), 64'b010);
    push(5'd7, 64'hDEAD_BEEF, 1'b0);
    tick();
    bus.req_valid = '0;
    #1;
    check("single_wena", 64'(bus.wena), 64'd1);
    check("single_waddr", 64'(bus.waddr), 64'd7);
    check("single_wdata", bus.wdata, 64'hDEAD_BEEF);
    tick();
    check("hold_wena", 64'(bus.wena), 64'd0);
    check("hold_waddr", 64'(bus.waddr), 64'd7);
    check("hold_wdata", bus.wdata, 64'hDEAD_BEEF);

    // Reset returns the pointer to 0 before the fairness run
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_waddr", 64'(bus.waddr), 64'd0);

    // Fairness: all three valid for six back-to-back cycles
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 64'hA000_0000 + 64'(i));
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("fair_ready_%0d", c), 64'(bus.req_ready), 64'd1 << exp_order[c]);
      push(AW'(10 + exp_order[c]), 64'hA000_0000 + 64'(exp_order[c]), 1'b0);
      tick();
    end
    bus.req_valid = '0;
    tick();

    // Clear sweep with a colliding request from requester 0
    set_req(0, 5'd3, 64'h55);
    bus.req_valid = 3'b001;
    bus.clr_start = 1'b1;
    #1;
    check("clr_start_ready", 64'(bus.req_ready), 64'd0);
    push_sweep();
    tick();
    bus.clr_start = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      check("sweep_busy", 64'(bus.clr_busy), 64'd1);
      check("sweep_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    check("sweep_last_busy", 64'(bus.clr_busy), 64'd1);
    check("sweep_last_done", 64'(bus.clr_done), 64'd1);
    check("sweep_last_addr", 64'(bus.waddr), 64'd31);
    check("after_clr_ready", 64'(bus.req_ready), 64'b001);
    push(5'd3, 64'h55, 1'b0);
    tick();
    bus.req_valid = '0;
    check("post_clr_busy", 64'(bus.clr_busy), 64'd0);
    check("post_clr_wena", 64'(bus.wena), 64'd1);
    check("post_clr_waddr", 64'(bus.waddr), 64'd3);
    tick();

    // Second clr_start mid-sweep is ignored
    bus.clr_start = 1'b1;
    push_sweep();
    tick();
    for (int k = 1; k < DEPTH; k++) begin
      bus.clr_start = (k == 10);
      check("restart_busy", 64'(bus.clr_busy), 64'd1);
      tick();
    end
    bus.clr_start = 1'b0;
    check("restart_done", 64'(bus.clr_done), 64'd1);
    tick();
    check("restart_end_busy", 64'(bus.clr_busy), 64'd0);
    check("restart_end_wena", 64'(bus.wena), 64'd0);
    tick();

    // Reset in the middle of a sweep
    bus.clr_start = 1'b1;
    push_sweep();
    tick();
    bus.clr_start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("abort_wena", 64'(bus.wena), 64'd0);
    check("abort_busy", 64'(bus.clr_busy), 64'd0);
    check("abort_done", 64'(bus.clr_done), 64'd0);
    check("abort_waddr", 64'(bus.waddr), 64'd0);

    // Write to address 0 after the abort
    set_req(2, 5'd0, 64'h1234_5678_9ABC_DEF0);
    bus.req_valid = 3'b100;
    #1;
    check("abort_wr_ready", 64'(bus.req_ready), 64'b100);
    push(5'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    tick();
    bus.req_valid = '0;
    check("abort_wr_wena", 64'(bus.wena), 64'd1);
    check("abort_wr_waddr", 64'(bus.waddr), 64'd0);
    check("abort_wr_wdata", bus.wdata, 64'h1234_5678_9ABC_DEF0);
    tick();
    tick();

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Shares the single write port of the 32x64 register file among NREQ write requesters using a valid/ready handshake and round-robin grant.
- Contains a clear sequencer that sweeps all DEPTH entries to zero on command, using the same write port.
- Sits between the execution and load units and the register file's waddr/wdata/wena inputs.

Parameters:
NREQ, 3, number of write requesters (2..8)
AW, 5, register address width
DW, 64, register data width
DEPTH, 32, number of registers swept by a clear (equals 2**AW)

Ports:
clk  in  1  clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester write request
req_addr  in  NREQ*AW  packed target addresses; requester i at [i*AW +: AW]
req_data  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
req_ready  out  NREQ  per-requester accept; at most one bit high
clr_start  in  1  single-cycle pulse requesting a full clear
clr_busy  out  1  high while the clear sweep is running
clr_done  out  1  single-cycle pulse on clear completion
waddr  out  AW  register-file write address
wdata  out  DW  register-file write data
wena  out  1  register-file write enable

Behaviour:
- Reset, synchronous and active-high: state=ARB; rr pointer=0; wena=0; waddr=0; wdata=0; clr_busy=0; clr_done=0; clear counter=0.
- States:
  - ARB: normal arbitration.
  - CLEAR: sweep.
  - ARB->CLEAR when clr_start=1.
  - CLEAR->ARB after the write to address DEPTH-1 is issued.
- ARB grant:
  - Combinational search over req_valid, starting at the rr pointer and wrapping modulo NREQ.
  - req_ready[g]=1 for the first valid index g only. req_ready is combinational from req_valid and state.
  - req_ready is all zero when no requester is valid, in CLEAR, or in any cycle where clr_start=1.
- Transfer: occurs when req_valid[g] and req_ready[g] are both high. On the next posedge: wena=1, waddr=req_addr[g], wdata=req_data[g]. Latency is one cycle from handshake to the write-port strobe.
- No transfer in a cycle: wena=0 next cycle; waddr and wdata hold their last values.
- Pointer: after a transfer, rr pointer = (g+1) mod NREQ. It is unchanged when there is no transfer. Back-to-back transfers are allowed every cycle.
- A requester holds valid, addr and data stable until it sees ready. Dropping valid before ready is permitted and causes no write.
- clr_start and request in the same cycle: clear wins, no request is accepted, and the request waits.
- CLEAR:
  - Counter starts at 0 in the cycle clr_start is sampled.
  - Each cycle the block writes wena=1, waddr=counter, wdata=0 on the following posedge, then increments the counter.
  - The sweep takes exactly DEPTH write cycles.
  - clr_busy=1 from the cycle after clr_start through the cycle with the last wena.
  - clr_done=1 for one cycle together with that last wena; the state returns to ARB on the same edge.
- clr_start during CLEAR is ignored: no restart and no extension.
- clr_start arriving in the cycle after completion starts a fresh sweep.
- rst asserted mid-sweep: abort immediately. All outputs take reset values, with no clr_done pulse. Entries already cleared stay cleared; nothing else is rewritten.
- The rr pointer is not modified by a clear.
- A write to address 0 is passed through unaltered; the arbiter applies no register-0 special case.

Optional Feature:
- Macro REGFILE_ARB_FIXED_PRI_EN.
- Defined: fixed priority, where the lowest valid index always wins; the rr pointer logic is removed and the pointer is unused.
- Undefined (default): round-robin as specified above.
- All other behaviour, including clear and latency, is identical in both builds.

Decomposition:
- Package regfile_pkg holds:
  - AW, DW, DEPTH constants, shared with the register file.
  - State encoding typedef: ARB=1'b0, CLEAR=1'b1.
- One sub-module: rr_arbiter. Parameter NREQ; inputs req, ptr and fixed_pri_sel; outputs onehot grant and grant index.

Test Plan:
- Reset then idle: no req_valid for 5 cycles -> wena=0, waddr=0, wdata=0, req_ready=0, clr_busy=0.
- Single write: req_valid=3'b010, addr1=5'd7, data1=64'hDEAD_BEEF -> req_ready=3'b010 same cycle; next cycle wena=1, waddr=7, wdata=DEAD_BEEF.
- Fairness: all three valid, held for 6 cycles -> grant order 0,1,2,0,1,2; with REGFILE_ARB_FIXED_PRI_EN -> 0,0,0,0,0,0.
- Clear sweep: pulse clr_start with req_valid=3'b001 in the same cycle -> no ready; 32 consecutive wena with waddr 0..31 and wdata=0; clr_done only with waddr=31; requester 0 is accepted the cycle after.
- Ignored restart: second clr_start at sweep cycle 10 -> exactly 32 writes total, one clr_done.
- Reset mid-clear: rst at sweep cycle 15 -> next cycle wena=0, clr_busy=0, no clr_done; a subsequent single write completes normally with one-cycle latency.
